dmem_byte_ctrl: RTL and testbench

//   Parametrised single-port data memory for the CPU datapath: byte-addressed, per-byte write

---
 rtl/dmem_byte_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_byte_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_ctrl.sv
// Byte-addressed single-port data memory with per-byte write enables,
// registered read, alignment/range checking and a post-reset clear sweep.
module dmem_byte_ctrl #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 1024,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [DATA_WIDTH/8-1:0]   ByteEn,
    input  logic [ADDRESS_WIDTH-1:0]  Address,
    input  logic [DATA_WIDTH-1:0]     WriteData,
    output logic [DATA_WIDTH-1:0]     MemData,
    output logic                      ReadValid,
    output logic                      Ready,
    output logic                      AddrErr
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'(BYTES - 1);
    localparam logic [IW-1:0]            LAST     = IW'(DEPTH - 1);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]         cnt;
    logic [IW-1:0]         cnt_next;
    logic                  ready;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [31:0]   word_idx;
    logic [IW-1:0] idx;
    logic          addr_ok;
    logic          req;
    logic          wr_ok;
    logic          rd_ok;

    // Address decode: word index plus alignment/range qualification.
    assign word_idx = 32'(Address >> OFF);
    assign idx      = word_idx[IW-1:0];
    assign addr_ok  = ~|(Address & OFF_MASK) && (word_idx < 32'(DEPTH));

    // Only requests seen while ready are acted on; write wins over read.
    assign req   = ready && (MemRead || MemWrite);
    assign wr_ok = ready && MemWrite && addr_ok;
    assign rd_ok = ready && MemRead && !MemWrite && addr_ok;

    assign Ready = ready;

    // Sweep sequencing: walk every word once, then park in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            INIT: begin
                cnt_next = cnt + IW'(1);
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            IDLE: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, sweep counter and ready flag; ready tracks the state we enter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= INIT_ON_RESET ? INIT : IDLE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            ready <= (state_next == IDLE);
        end
    end

    // Storage: clear sweep has the port while in INIT, else byte writes.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
            end else if (wr_ok) begin
                for (int i = 0; i < BYTES; i++) begin
                    if (ByteEn[i]) begin
                        mem[idx][8*i +: 8] <= WriteData[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read data and one-cycle status pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            MemData   <= '0;
            ReadValid <= 1'b0;
            AddrErr   <= 1'b0;
        end else begin
            ReadValid <= rd_ok;
            AddrErr   <= req && !addr_ok;
            if (rd_ok) begin
                MemData <= mem[idx];
            end
        end
    end

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Scoreboard bench for dmem_byte_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever the DUT responds.
module tb_dmem_byte_ctrl;

    localparam int DEPTH = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [3:0]  ByteEn = '0;
    logic [15:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] MemData;
    logic        ReadValid;
    logic        Ready;
    logic        AddrErr;

    dmem_byte_ctrl #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (32),
        .DEPTH        (DEPTH),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ByteEn   (ByteEn),
        .Address  (Address),
        .WriteData(WriteData),
        .MemData  (MemData),
        .ReadValid(ReadValid),
        .Ready    (Ready),
        .AddrErr  (AddrErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          busy = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd = '0;

    // Reference model: decide the response from the addressing rules.
    task automatic step(input bit rd, input bit wr, input logic [3:0] be,
                        input logic [15:0] addr, input logic [31:0] data);
        int   w;
        bit   ok;
        exp_t e;
        n_vec++;
        if (Ready !== (busy == 0)) begin
            n_bad++;
            $display("FAIL ready: got %b want %b (busy=%0d)", Ready, busy == 0, busy);
        end
        if (busy == 0 && (rd || wr)) begin
            w  = int'(addr) / 4;
            ok = (int'(addr) % 4 == 0) && (w < DEPTH);
            if (!ok) begin
                e.err  = 1'b1;
                e.data = last_rd;
                q.push_back(e);
            end else if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
            end else begin
                e.err   = 1'b0;
                e.data  = ref_mem[w];
                last_rd = ref_mem[w];
                q.push_back(e);
            end
        end
        MemRead   = rd;
        MemWrite  = wr;
        ByteEn    = be;
        Address   = addr;
        WriteData = data;
        @(posedge Clk);
        if (busy > 0) busy--;
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'h0, 16'h0, 32'h0);
    endtask

    task automatic do_reset();
        Rst      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        busy    = DEPTH;
        last_rd = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        n_vec++;
        if (MemData !== 32'h0 || ReadValid !== 1'b0 ||
            AddrErr !== 1'b0 || Ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got data=%h rv=%b err=%b rdy=%b want 0/0/0/0",
                     MemData, ReadValid, AddrErr, Ready);
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 4'h0, 16'(i * 4), 32'h0);
    endtask

    // Monitor: every DUT response must match the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (ReadValid === 1'b1 || AddrErr === 1'b1) begin
            n_vec++;
            if (ReadValid === 1'b1 && AddrErr === 1'b1) begin
                n_bad++;
                $display("FAIL excl: ReadValid and AddrErr both high");
                if (q.size() != 0) void'(q.pop_front());
            end else if (q.size() == 0) begin
                n_bad++;
                $display("FAIL spurious: rv=%b err=%b data=%h want no response",
                         ReadValid, AddrErr, MemData);
            end else begin
                e = q.pop_front();
                if (AddrErr !== e.err || MemData !== e.data) begin
                    n_bad++;
                    $display("FAIL resp: got err=%b data=%h want err=%b data=%h",
                             AddrErr, MemData, e.err, e.data);
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        int          sel;

        do_reset();
        idle(DEPTH + 1);
        read_all();

        step(0, 1, 4'b1111, 16'h0004, 32'hDEADBEEF);
        step(0, 1, 4'b0010, 16'h0004, 32'h0000AA00);
        step(1, 0, 4'b0000, 16'h0004, 32'h0);
        idle(1);
        step(1, 0, 4'b0000, 16'h0002, 32'h0);
        step(1, 0, 4'b0000, 16'h0040, 32'h0);
        step(0, 1, 4'b1111, 16'h0041, 32'hFFFFFFFF);
        step(0, 1, 4'b0000, 16'h000C, 32'hFFFFFFFF);
        step(1, 1, 4'b1111, 16'h0008, 32'h12345678);
        step(1, 0, 4'b0000, 16'h0008, 32'h0);
        step(1, 0, 4'b0000, 16'h000C, 32'h0);

        step(0, 1, 4'b1111, 16'h0010, 32'hCAFEF00D);
        step(0, 1, 4'b1111, 16'h0014, 32'h0BADC0DE);
        do_reset();
        for (int i = 0; i < 5; i++)
            step(i % 2 == 0, 1, 4'b1111, 16'(i * 4), 32'hA5A5A5A5);
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            step(i % 3 == 0, i % 3 == 1, 4'b1111, 16'(i * 4 + (i % 4)), 32'h5A5A5A5A);
        idle(1);
        read_all();

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 16'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel < 9) a = 16'($urandom_range(0, 16'h7F));
            else              a = 16'($urandom);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 4'($urandom), a, $urandom);
        end

        idle(3);
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
